// File: rtl/ika87ad_microcode_sequencer_pkg.sv
// Shared mnemonics for the IKA87AD microcode path: bus-cycle codes,
// microword field positions, sequencer states and the fixed parking
// addresses used by the micro-program sequencer.
package ika87ad_microcode_sequencer_pkg;

    // Bus-cycle request carried in the low two bits of every microword.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_RD3  = 2'b01,
        BUS_WR3  = 2'b10,
        BUS_RD4  = 2'b11
    } buscycle_e;

    // Microword layout: [17:16] type, [15] flag, [14] skip,
    // [13:2] type payload, [1:0] bus cycle.
    localparam int MC_FLAG_BIT = 15;
    localparam int MC_SKIP_BIT = 14;
    localparam int MC_BUS_HI   = 1;
    localparam int MC_BUS_LO   = 0;

    // Decode-wait parking address and the reset entry (a plain RD4 word).
    localparam logic [7:0] IRD_ADDR_DEF = 8'hFE;
    localparam logic [7:0] NOP_ADDR_DEF = 8'hFF;

    // One microstep is ISSUE -> LATCH -> WAIT; DECODE sits between instructions.
    typedef enum logic [1:0] {
        S_ISSUE  = 2'd0,
        S_LATCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_DECODE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ika87ad_microcode_sequencer.sv
// Micro-program sequencer: walks the micro-PC through the microcode ROM one
// bus cycle per microstep, latches each word for the datapath and bus unit,
// and applies the PSW skip condition by turning the first SKIP-marked step
// of a skipped instruction into a suppressed terminal RD4.
module ika87ad_microcode_sequencer
    import ika87ad_microcode_sequencer_pkg::*;
#(
    parameter int                   MC_WIDTH = 18,
    parameter int                   MA_WIDTH = 8,
    parameter logic [MA_WIDTH-1:0]  IRD_ADDR = IRD_ADDR_DEF,
    parameter logic [MA_WIDTH-1:0]  NOP_ADDR = NOP_ADDR_DEF
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_n,
    input  logic                 i_CYCLE_END,
    input  logic                 i_DECODE_VALID,
    input  logic [MA_WIDTH-1:0]  i_DECODE_ADDR,
    input  logic                 i_SKIP_FLAG,
    input  logic [MC_WIDTH-1:0]  i_MCROM_DATA,
    output logic                 o_MCROM_READ_TICK,
    output logic [MA_WIDTH-1:0]  o_MCROM_ADDR,
    output logic [MC_WIDTH-1:0]  o_MC_WORD,
    output logic                 o_MC_VALID,
    output logic [1:0]           o_BUSCYCLE,
    output logic                 o_FLAG_EN,
    output logic                 o_SUPPRESS,
    output logic                 o_INSTR_END,
    output logic                 o_SKIP_CLR,
    output logic                 o_DECODE_ACK
);

    seq_state_e           state_q, state_d;
    logic [MA_WIDTH-1:0]  upc_q, upc_d;
    logic [MC_WIDTH-1:0]  word_q, word_d;
    logic                 skip_active_q, skip_active_d;
    logic                 suppress_q, suppress_d;
    logic                 mc_valid_q, mc_valid_d;
    logic                 instr_end_q, instr_end_d;
    logic                 skip_clr_q, skip_clr_d;
    logic                 decode_ack_q, decode_ack_d;

    logic                 step_is_rd4;
    logic                 skip_hit;

    // The held word's bus field decides whether this step ends the instruction.
    assign step_is_rd4 = (word_q[MC_BUS_HI:MC_BUS_LO] == BUS_RD4);
    // A SKIP-marked word arriving while the instruction is being skipped.
    assign skip_hit    = skip_active_q && i_MCROM_DATA[MC_SKIP_BIT];

    // State, micro-PC, latched word and strobe registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before this edge.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q       <= S_ISSUE;
            upc_q         <= NOP_ADDR;
            word_q        <= '0;
            skip_active_q <= 1'b0;
            suppress_q    <= 1'b0;
            mc_valid_q    <= 1'b0;
            instr_end_q   <= 1'b0;
            skip_clr_q    <= 1'b0;
            decode_ack_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            upc_q         <= upc_d;
            word_q        <= word_d;
            skip_active_q <= skip_active_d;
            suppress_q    <= suppress_d;
            mc_valid_q    <= mc_valid_d;
            instr_end_q   <= instr_end_d;
            skip_clr_q    <= skip_clr_d;
            decode_ack_q  <= decode_ack_d;
        end
    end

    // Next-state: fixed ISSUE/LATCH hop, then wait for the bus unit or decoder.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ISSUE:  state_d = S_LATCH;
            S_LATCH:  state_d = S_WAIT;
            S_WAIT: begin
                if (i_CYCLE_END) begin
                    state_d = step_is_rd4 ? S_DECODE : S_ISSUE;
                end
            end
            S_DECODE: begin
                if (i_DECODE_VALID) begin
                    state_d = S_ISSUE;
                end
            end
            default:  state_d = S_ISSUE;
        endcase
    end

    // Next values for micro-PC, microword, skip/suppress latches and strobes.
    // NOTE: every target gets a default before the case so no latch is inferred.
    always_comb begin
        upc_d         = upc_q;
        word_d        = word_q;
        skip_active_d = skip_active_q;
        suppress_d    = suppress_q;
        mc_valid_d    = 1'b0;
        instr_end_d   = 1'b0;
        skip_clr_d    = 1'b0;
        decode_ack_d  = 1'b0;
        unique case (state_q)
            S_ISSUE: begin
            end
            S_LATCH: begin
                word_d     = i_MCROM_DATA;
                mc_valid_d = 1'b1;
                if (skip_hit) begin
                    // The skipped step becomes the opcode fetch that ends the instruction.
                    word_d[MC_BUS_HI:MC_BUS_LO] = BUS_RD4;
                    suppress_d                  = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_CYCLE_END) begin
                    if (step_is_rd4) begin
                        instr_end_d   = 1'b1;
                        upc_d         = IRD_ADDR;
                        suppress_d    = 1'b0;
                        skip_active_d = 1'b0;
                    end else begin
                        // Plain binary increment: FFh wraps to 00h.
                        upc_d = upc_q + MA_WIDTH'(1);
                    end
                end
            end
            S_DECODE: begin
                if (i_DECODE_VALID) begin
                    upc_d         = i_DECODE_ADDR;
                    skip_active_d = i_SKIP_FLAG;
                    decode_ack_d  = 1'b1;
                    skip_clr_d    = i_SKIP_FLAG;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs: ROM interface from the state, everything else from the latched word.
    always_comb begin
        o_MCROM_READ_TICK = (state_q == S_ISSUE);
        o_MCROM_ADDR      = upc_q;
        o_MC_WORD         = word_q;
        o_MC_VALID        = mc_valid_q;
        o_BUSCYCLE        = (state_q == S_DECODE) ? BUS_IDLE : word_q[MC_BUS_HI:MC_BUS_LO];
        o_FLAG_EN         = word_q[MC_FLAG_BIT] & ~suppress_q;
        o_SUPPRESS        = suppress_q;
        o_INSTR_END       = instr_end_q;
        o_SKIP_CLR        = skip_clr_q;
        o_DECODE_ACK      = decode_ack_q;
    end

endmodule

// File: tb/tb_ika87ad_microcode_sequencer.sv
// Self-checking bench for the microcode sequencer. The bench plays the ROM
// (one-cycle read latency), the bus unit and the opcode decoder, and predicts
// each instruction's microstep sequence from the ROM contents and skip rule.
module tb_ika87ad_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_CYCLE_END;
    logic        i_DECODE_VALID;
    logic [7:0]  i_DECODE_ADDR;
    logic        i_SKIP_FLAG;
    logic [17:0] rom_q;
    logic        o_MCROM_READ_TICK;
    logic [7:0]  o_MCROM_ADDR;
    logic [17:0] o_MC_WORD;
    logic        o_MC_VALID;
    logic [1:0]  o_BUSCYCLE;
    logic        o_FLAG_EN;
    logic        o_SUPPRESS;
    logic        o_INSTR_END;
    logic        o_SKIP_CLR;
    logic        o_DECODE_ACK;

    logic [17:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [17:0] W_FLAG = 18'h08000;
    localparam logic [17:0] W_SKIP = 18'h04000;
    localparam logic [1:0]  RD3    = 2'b01;
    localparam logic [1:0]  WR3    = 2'b10;
    localparam logic [1:0]  RD4    = 2'b11;

    typedef struct {
        logic [7:0] entry;
        bit         sk;
        int         steps;
        bit         last_supp;
        bit         last_flag;
    } vec_t;

    vec_t vecs [7];

    ika87ad_microcode_sequencer dut (
        .i_CLK             (clk),
        .i_RST_n           (rst_n),
        .i_CYCLE_END       (i_CYCLE_END),
        .i_DECODE_VALID    (i_DECODE_VALID),
        .i_DECODE_ADDR     (i_DECODE_ADDR),
        .i_SKIP_FLAG       (i_SKIP_FLAG),
        .i_MCROM_DATA      (rom_q),
        .o_MCROM_READ_TICK (o_MCROM_READ_TICK),
        .o_MCROM_ADDR      (o_MCROM_ADDR),
        .o_MC_WORD         (o_MC_WORD),
        .o_MC_VALID        (o_MC_VALID),
        .o_BUSCYCLE        (o_BUSCYCLE),
        .o_FLAG_EN         (o_FLAG_EN),
        .o_SUPPRESS        (o_SUPPRESS),
        .o_INSTR_END       (o_INSTR_END),
        .o_SKIP_CLR        (o_SKIP_CLR),
        .o_DECODE_ACK      (o_DECODE_ACK)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the read tick.
    always @(posedge clk) begin
        if (o_MCROM_READ_TICK) rom_q <= rom[o_MCROM_ADDR];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_MCROM_READ_TICK) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_MC_VALID) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One microstep: expect the tick at exp_addr, the word exp_word, then end
    // the bus cycle after 'delay' extra cycles (decoder noise injected meanwhile).
    task automatic do_step(input logic [7:0] exp_addr, input logic [17:0] exp_word,
                           input bit exp_supp, input int delay);
        bit ok;
        wait_tick(ok);
        check("tick seen", 32'(ok), 32'd1);
        check("rom addr", 32'(o_MCROM_ADDR), 32'(exp_addr));
        @(negedge clk);
        wait_valid(ok);
        check("valid seen", 32'(ok), 32'd1);
        check("mc word", 32'(o_MC_WORD), 32'(exp_word));
        check("suppress", 32'(o_SUPPRESS), 32'(exp_supp));
        check("flag_en", 32'(o_FLAG_EN), 32'(exp_word[15] & ~exp_supp));
        check("buscycle", 32'(o_BUSCYCLE), 32'(exp_word[1:0]));
        for (int i = 0; i < delay; i++) begin
            i_DECODE_VALID = 1'($urandom_range(0, 1));
            i_DECODE_ADDR  = 8'($urandom);
            @(negedge clk);
            i_DECODE_VALID = 1'b0;
        end
        if (delay > 0) check("word held", 32'(o_MC_WORD), 32'(exp_word));
        i_CYCLE_END = 1'b1;
        @(negedge clk);
        i_CYCLE_END = 1'b0;
        check("instr_end", 32'(o_INSTR_END), 32'(exp_word[1:0] == RD4));
    endtask

    // Instruction-level model: walk the ROM from the entry; a SKIP-marked word
    // while skipping becomes a suppressed RD4; any RD4 retires the instruction.
    task automatic run_instr(input logic [7:0] entry, input bit sk,
                             output int steps, output bit last_supp, output bit last_flag);
        logic [7:0]  pc;
        logic [17:0] w;
        bit          supp;
        bit          done;
        pc = entry;
        steps = 0;
        done = 1'b0;
        last_supp = 1'b0;
        last_flag = 1'b0;
        for (int s = 0; s < 64; s++) begin
            w = rom[pc];
            supp = sk && w[14];
            if (supp) w[1:0] = RD4;
            do_step(pc, w, supp, int'($urandom_range(0, 3)));
            steps++;
            if (w[1:0] == RD4) begin
                last_supp = supp;
                last_flag = w[15] & ~supp;
                done = 1'b1;
                break;
            end
            pc = pc + 8'd1;
        end
        check("instr terminated", 32'(done), 32'd1);
        check("decode bus idle", 32'(o_BUSCYCLE), 32'd0);
        check("decode no tick", 32'(o_MCROM_READ_TICK), 32'd0);
    endtask

    // Hand the sequencer a decoded entry after 'delay' idle cycles of bus noise.
    task automatic do_decode(input logic [7:0] entry, input bit sk, input int delay);
        for (int i = 0; i < delay; i++) begin
            check("wait no tick", 32'(o_MCROM_READ_TICK), 32'd0);
            check("wait bus idle", 32'(o_BUSCYCLE), 32'd0);
            i_CYCLE_END = 1'($urandom_range(0, 1));
            @(negedge clk);
            i_CYCLE_END = 1'b0;
        end
        i_DECODE_VALID = 1'b1;
        i_DECODE_ADDR  = entry;
        i_SKIP_FLAG    = sk;
        @(negedge clk);
        i_DECODE_VALID = 1'b0;
        i_SKIP_FLAG    = 1'($urandom_range(0, 1));
        check("decode_ack", 32'(o_DECODE_ACK), 32'd1);
        check("skip_clr", 32'(o_SKIP_CLR), 32'(sk));
    endtask

    initial begin
        int  steps;
        bit  lsupp;
        bit  lflag;
        bit  ok;

        rst_n          = 1'b0;
        i_CYCLE_END    = 1'b0;
        i_DECODE_VALID = 1'b0;
        i_DECODE_ADDR  = 8'h00;
        i_SKIP_FLAG    = 1'b0;
        for (int a = 0; a < 256; a++) rom[a] = 18'h0;
        rom[8'hFF] = 18'h00003;
        rom[8'h10] = 18'h10124 | 18'(RD3);
        rom[8'h11] = W_FLAG | W_SKIP | 18'h00A08 | 18'(RD4);
        rom[8'h20] = 18'h20040 | 18'(RD3);
        rom[8'h21] = 18'h00880 | 18'(WR3);
        rom[8'h22] = 18'h30004 | 18'(RD4);
        rom[8'h40] = W_FLAG | W_SKIP | 18'h01230;
        rom[8'h41] = 18'h20010 | 18'(RD4);
        rom[8'h00] = 18'h00003;

        vecs[0] = '{8'h10, 1'b0, 2, 1'b0, 1'b1};
        vecs[1] = '{8'h10, 1'b1, 2, 1'b1, 1'b0};
        vecs[2] = '{8'h20, 1'b1, 3, 1'b0, 1'b0};
        vecs[3] = '{8'h40, 1'b0, 2, 1'b0, 1'b0};
        vecs[4] = '{8'h40, 1'b1, 1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 2, 1'b0, 1'b0};
        vecs[6] = '{8'h20, 1'b0, 3, 1'b0, 1'b0};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst mc_word", 32'(o_MC_WORD), 32'd0);
        check("rst mc_valid", 32'(o_MC_VALID), 32'd0);
        check("rst instr_end", 32'(o_INSTR_END), 32'd0);
        check("rst skip_clr", 32'(o_SKIP_CLR), 32'd0);
        check("rst decode_ack", 32'(o_DECODE_ACK), 32'd0);
        check("rst suppress", 32'(o_SUPPRESS), 32'd0);
        check("rst flag_en", 32'(o_FLAG_EN), 32'd0);
        check("rst buscycle", 32'(o_BUSCYCLE), 32'd0);
        check("rst addr", 32'(o_MCROM_ADDR), 32'hFF);
        rst_n = 1'b1;

        // First fetch after reset: the NOP word at FFh is a single RD4 step.
        run_instr(8'hFF, 1'b0, steps, lsupp, lflag);
        check("nop steps", 32'(steps), 32'd1);

        // FFh now holds a non-RD4 word so entering there exercises the wrap.
        rom[8'hFF] = 18'h00101 ;

        for (int v = 0; v < 7; v++) begin
            do_decode(vecs[v].entry, vecs[v].sk, int'($urandom_range(0, 3)));
            run_instr(vecs[v].entry, vecs[v].sk, steps, lsupp, lflag);
            check($sformatf("vec%0d steps", v), 32'(steps), 32'(vecs[v].steps));
            check($sformatf("vec%0d last suppress", v), 32'(lsupp), 32'(vecs[v].last_supp));
            check($sformatf("vec%0d last flag_en", v), 32'(lflag), 32'(vecs[v].last_flag));
        end

        // Reset while waiting on the second LXI step: outputs drop at once.
        rom[8'hFF] = 18'h00003;
        do_decode(8'h20, 1'b0, 0);
        do_step(8'h20, rom[8'h20], 1'b0, 0);
        wait_tick(ok);
        check("lxi tick", 32'(ok), 32'd1);
        check("lxi addr", 32'(o_MCROM_ADDR), 32'h21);
        @(negedge clk);
        wait_valid(ok);
        check("lxi word", 32'(o_MC_WORD), 32'(rom[8'h21]));
        #2 rst_n = 1'b0;
        #1;
        check("abort mc_word", 32'(o_MC_WORD), 32'd0);
        check("abort mc_valid", 32'(o_MC_VALID), 32'd0);
        check("abort addr", 32'(o_MCROM_ADDR), 32'hFF);
        check("abort buscycle", 32'(o_BUSCYCLE), 32'd0);
        check("abort suppress", 32'(o_SUPPRESS), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(8'hFF, 1'b0, steps, lsupp, lflag);
        check("restart steps", 32'(steps), 32'd1);

        // Random ROM contents and random instruction stream.
        for (int a = 0; a < 256; a++) begin
            rom[a] = 18'($urandom);
            if ((a % 4) == 3) rom[a][1:0] = RD4;
        end
        for (int n = 0; n < 40; n++) begin
            logic [7:0] e;
            bit         s;
            e = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            do_decode(e, s, int'($urandom_range(0, 3)));
            run_instr(e, s, steps, lsupp, lflag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ika87ad_microcode_sequencer.md
Name: ika87ad_microcode_sequencer

Overview:
Micro-program sequencer that drives the microcode ROM's address and read-tick inputs and consumes its 18-bit words. It holds the micro-PC, steps through multi-cycle instructions one bus cycle per microstep, and returns to the decode-wait entry when a step requests an opcode fetch (RD4). It also applies the PSW skip condition, and hands each latched microword to the execution datapath and the bus unit.

Parameters:
MC_WIDTH, 18, microword width.
MA_WIDTH, 8, micro-address width.
IRD_ADDR, 8'hFE, micro-address the sequencer parks on while waiting for the opcode decoder.
NOP_ADDR, 8'hFF, micro-address loaded at reset; its word is a plain RD4 that fetches the first opcode.

Ports:
i_CLK  in  1  system clock
i_RST_n  in  1  asynchronous active-low reset
i_CYCLE_END  in  1  one-cycle strobe from the bus unit: current bus cycle (IDLE/RD3/WR3/RD4) complete
i_DECODE_VALID  in  1  opcode decoder has a valid entry address
i_DECODE_ADDR  in  8  micro-address of the decoded instruction's first step
i_SKIP_FLAG  in  1  PSW.SK, sampled at instruction start
i_MCROM_DATA  in  18  ROM word, valid the cycle after the read tick
o_MCROM_READ_TICK  out  1  ROM read enable
o_MCROM_ADDR  out  8  ROM address (= micro-PC)
o_MC_WORD  out  18  latched microword, bus field possibly overridden
o_MC_VALID  out  1  one-cycle strobe: o_MC_WORD updated
o_BUSCYCLE  out  2  bus-cycle request = o_MC_WORD[1:0]
o_FLAG_EN  out  1  o_MC_WORD[15] and not suppressed
o_SUPPRESS  out  1  datapath must not commit this step
o_INSTR_END  out  1  one-cycle strobe: instruction retired
o_SKIP_CLR  out  1  one-cycle strobe: clear PSW.SK
o_DECODE_ACK  out  1  one-cycle strobe: decode address consumed

Behaviour:
- Reset (asynchronous): state=S_ISSUE, micro-PC=NOP_ADDR, o_MC_WORD=0, skip_active=0.
- Reset values of strobes: o_MC_VALID, o_INSTR_END, o_SKIP_CLR, o_DECODE_ACK all 0.
- Reset values of derived outputs: o_SUPPRESS=0, o_FLAG_EN=0, o_BUSCYCLE=IDLE. o_MCROM_READ_TICK is 0 after release until the first S_ISSUE cycle.
- Microword fields: [17:16] MCTYPE, [15] FLAG, [14] SKIP, [13:2] type payload (passed through), [1:0] bus cycle.
- Bus-cycle codes: IDLE=00, RD3=01, WR3=10, RD4=11.
- S_ISSUE: assert o_MCROM_READ_TICK for exactly 1 cycle, address=micro-PC; go to S_LATCH.
- S_LATCH: o_MC_WORD<=i_MCROM_DATA; o_MC_VALID=1; go to S_WAIT.
  - If skip_active and word[14]=1: bus field is forced to RD4 and the suppress latch is set.
  - Suppress is sticky until instruction end; o_SUPPRESS reflects it from this word onward.
- S_WAIT: hold o_MC_WORD until i_CYCLE_END. i_CYCLE_END in any other state is ignored.
  - On i_CYCLE_END with bus=RD4: pulse o_INSTR_END; micro-PC<=IRD_ADDR; clear suppress and skip_active; go to S_DECODE.
  - On i_CYCLE_END otherwise: micro-PC<=micro-PC+1 (mod 256, FFh wraps to 00h); go to S_ISSUE.
- S_DECODE: wait for i_DECODE_VALID. While waiting, o_BUSCYCLE=IDLE and the read tick stays low.
  - When i_DECODE_VALID is seen: micro-PC<=i_DECODE_ADDR; skip_active<=i_SKIP_FLAG; pulse o_DECODE_ACK. If i_SKIP_FLAG=1, also pulse o_SKIP_CLR. Go to S_ISSUE.
  - i_DECODE_VALID outside S_DECODE is ignored.
- Minimum microstep length: 3 cycles (issue, latch, wait with same-cycle end strobe).
- Skipped instruction: steps before the first SKIP-marked word run normally, so operand bytes are still fetched. The SKIP-marked step becomes the terminal RD4 with o_SUPPRESS=1.
- FLAG: o_FLAG_EN = word[15] & ~suppress.
- Reset mid-instruction aborts immediately; the next opcode fetch restarts from NOP_ADDR.

Decomposition:
- The shared IKA87AD_mnemonics package gains:
  - bus-cycle code constants (IDLE/RD3/WR3/RD4);
  - microword field-position constants;
  - the sequencer state enum;
  - IRD/NOP addresses as named constants, used as the parameter defaults.
- No sub-module: a single FSM plus the micro-PC register. The ROM is instantiated beside it at the top level, not inside.

Test Plan:
- Reset release -> tick at 8'hFF; ROM returns RD4 word; i_CYCLE_END -> o_INSTR_END=1, state S_DECODE, o_BUSCYCLE=IDLE.
- Decode MVI entry 8'h10 (word0 RD3, word1 SKIP=1 FLAG=1 RD4), SK=0 -> addresses 10h, 11h ticked. Step 2 has o_FLAG_EN=1, o_SUPPRESS=0; instruction ends after the second i_CYCLE_END.
- Same MVI with i_SKIP_FLAG=1 -> o_SKIP_CLR and o_DECODE_ACK pulse. Step 10h RD3 with o_SUPPRESS=0; step 11h has o_SUPPRESS=1 and o_FLAG_EN=0.
- Decode MUL entry 8'h40 (word0 SKIP=1, IDLE), SK=1 -> single step: bus field forced to RD4, o_SUPPRESS=1, 41h never ticked.
- Entry 8'hFF with a non-RD4 word -> next tick address is 00h (wrap).
- i_RST_n low while in S_WAIT mid-LXI -> outputs return to reset values asynchronously; after release, first tick is at FFh.
